writeback_arbiter: RTL

- Writeback stage directly upstream of the register file write port.
- Merges two result sources onto the single register-file write port (wb_reg_write/wb_rd/wb_data):
  - the in-order execute pipe, which cannot stall and always has priority;
  - the long-latency load/store unit (LSU), whose results are buffered in a small FIFO and drained into idle writeback slots.
- Keeps a pending-load scoreboard so hazard logic can stall on registers awaiting LSU data.

---
 rtl/writeback_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the execute pipe and the LSU onto the single
// register-file write port and tracks the registers that still await load data.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   pipe_valid/pipe_rd/pipe_data execute-pipe result (highest priority, no backpressure)
//   lsu_valid/lsu_rd/lsu_data    LSU result offer; accepted when lsu_ready is high
//   lsu_ready                    LSU FIFO has room (combinational from state)
//   issue_valid/issue_rd         load issued; marks issue_rd busy
//   wb_reg_write/wb_rd/wb_data   registered register-file write port
//   busy                         pending-load bitmap (bit n = xn awaits LSU data)
//   fifo_count                   LSU FIFO occupancy
//
// Optional feature macro: WB_LSU_BYPASS_EN
//   When defined, an LSU result offered into an empty FIFO during a cycle with
//   no pipe result is written straight into the wb_* registers (1-cycle latency).
module writeback_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pipe_valid,
    input  logic [4:0]                    pipe_rd,
    input  logic [XLEN-1:0]               pipe_data,
    input  logic                          lsu_valid,
    input  logic [4:0]                    lsu_rd,
    input  logic [XLEN-1:0]               lsu_data,
    output logic                          lsu_ready,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    output logic                          wb_reg_write,
    output logic [4:0]                    wb_rd,
    output logic [XLEN-1:0]               wb_data,
    output logic [31:0]                   busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [31:0]      busy_q, busy_d;

    logic             fifo_empty_c;
    logic             bypass_c;
    logic             push_c;
    logic             pop_c;
    logic             sel_valid_c;
    logic             sel_lsu_c;
    wb_entry_t        sel_c;
    wb_entry_t        lsu_entry_c;

    // Handshake depends on state only, so a pop this cycle does not raise ready.
    assign lsu_ready    = (count_q != CNT_W'(FIFO_DEPTH));
    assign fifo_empty_c = (count_q == '0);
    assign lsu_entry_c  = '{rd: lsu_rd, data: lsu_data};

`ifdef WB_LSU_BYPASS_EN
    // Empty FIFO and an idle slot: skip the buffer entirely.
    assign bypass_c = fifo_empty_c && !pipe_valid && lsu_valid;
`else
    assign bypass_c = 1'b0;
`endif

    assign push_c = lsu_valid && lsu_ready && !bypass_c;
    assign pop_c  = !pipe_valid && !fifo_empty_c;

    // Writeback slot selection: pipe first, then FIFO head, then bypassed LSU.
    always_comb begin
        sel_valid_c = 1'b0;
        sel_lsu_c   = 1'b0;
        sel_c       = '0;
        if (pipe_valid) begin
            sel_valid_c = 1'b1;
            sel_c       = '{rd: pipe_rd, data: pipe_data};
        end else if (!fifo_empty_c) begin
            sel_valid_c = 1'b1;
            sel_lsu_c   = 1'b1;
            sel_c       = mem_q[rd_ptr_q];
        end else if (bypass_c) begin
            sel_valid_c = 1'b1;
            sel_lsu_c   = 1'b1;
            sel_c       = lsu_entry_c;
        end
    end

    // Next-state for pointers, occupancy, write port and pending-load bitmap.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        wb_reg_write_d = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        busy_d         = busy_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // x0 results are consumed but never written.
        if (sel_valid_c) begin
            wb_reg_write_d = (sel_c.rd != 5'd0);
            wb_rd_d        = sel_c.rd;
            wb_data_d      = sel_c.data;
        end

        // Clear first so a same-cycle issue to the same register wins.
        if (sel_valid_c && sel_lsu_c && (sel_c.rd != 5'd0)) begin
            busy_d[sel_c.rd] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            busy_q         <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            busy_q         <= busy_d;
        end
    end

    // FIFO storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= lsu_entry_c;
        end
    end

    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign busy         = busy_q;
    assign fifo_count   = count_q;

endmodule
